// File: rtl/hwpf_pkg.sv
// Shared types and default geometry for the stream prefetcher.
// The top level re-derives widths from its own parameters; these match the default build.
package hwpf_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 40;
  localparam int unsigned DEF_LINE_BYTES = 64;
  localparam int unsigned DEF_PAGE_BYTES = 4096;

  localparam int unsigned LINE_OFF_W = $clog2(DEF_LINE_BYTES);
  localparam int unsigned PAGE_OFF_W = $clog2(DEF_PAGE_BYTES);

  typedef logic [DEF_ADDR_WIDTH-LINE_OFF_W-1:0] line_addr_t;

  typedef enum logic [0:0] {
    HWPF_IDLE = 1'b0,
    HWPF_GEN  = 1'b1
  } hwpf_gen_state_e;

endpackage

// File: rtl/hwpf_req_queue.sv
// Small FIFO holding pending prefetch line addresses; head is visible combinationally.
// Fullness comes from the registered count, so a push into a full queue is refused even on a pop.
module hwpf_req_queue
  import hwpf_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_reg == CNT_W'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign head_o  = mem_reg[rd_ptr_reg];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (do_pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage needs no reset: an entry is only read once count covers it.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_reg[wr_ptr_reg] <= push_data_i;
  end

endmodule

// File: rtl/hwpf_stream.sv
// Next-N-line stream prefetcher: a line touched twice confirms a stream and up to
// degree sequential in-page lines are queued towards the cache arbiter.
module hwpf_stream
  import hwpf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned LINE_BYTES  = DEF_LINE_BYTES,
  parameter int unsigned PAGE_BYTES  = DEF_PAGE_BYTES,
  parameter int unsigned HIST_DEPTH  = 8,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned MAX_DEGREE  = 4,
  parameter int unsigned TID_WIDTH   = 7
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              lock_i,
  input  logic [$clog2(MAX_DEGREE+1)-1:0]   degree_i,
  input  logic                              cpu_req_valid_i,
  input  logic [ADDR_WIDTH-1:0]             cpu_req_addr_i,
  input  logic [TID_WIDTH-1:0]              cpu_req_tid_i,
  output logic                              arbiter_req_valid_o,
  input  logic                              arbiter_req_ready_i,
  output logic [ADDR_WIDTH-1:0]             arbiter_req_addr_o,
  output logic                              drop_o
);

  localparam int unsigned LOFF_W    = $clog2(LINE_BYTES);
  localparam int unsigned POFF_W    = $clog2(PAGE_BYTES);
  localparam int unsigned LINE_W    = ADDR_WIDTH - LOFF_W;
  localparam int unsigned PG_LINE_W = POFF_W - LOFF_W;
  localparam int unsigned DEG_W     = $clog2(MAX_DEGREE + 1);
  localparam int unsigned HPTR_W    = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

  typedef logic [LINE_W-1:0] line_t;

  hwpf_gen_state_e       state_reg, state_next;
  line_t                 gen_line_reg, gen_line_next;
  logic [DEG_W-1:0]      deg_reg, deg_next;
  logic [DEG_W-1:0]      k_reg, k_next;
  logic [DEG_W-1:0]      eff_deg;

  logic [TID_WIDTH-1:0]  last_tid_reg;
  logic                  last_tid_valid_reg;
  logic                  trigger;

  line_t                 hist_line_reg [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_valid_reg;
  logic [HPTR_W-1:0]     hist_ptr_reg;
  logic [HIST_DEPTH-1:0] hit_vec;
  logic                  hist_hit;
  logic                  hist_wr;

  line_t                 trig_line, cand_line, lookup_line;
  logic                  cand_cross;

  logic                  q_push, q_pop, q_full, q_empty;
  line_t                 q_head;

  logic                  drop_ev, drop_reg;
  logic                  addr_offset_unused;

  assign trig_line          = cpu_req_addr_i[ADDR_WIDTH-1:LOFF_W];
  assign addr_offset_unused = ^cpu_req_addr_i[LOFF_W-1:0];

  assign trigger = cpu_req_valid_i & ~lock_i &
                   (~last_tid_valid_reg | (cpu_req_tid_i != last_tid_reg));

  assign eff_deg = (degree_i > DEG_W'(MAX_DEGREE)) ? DEG_W'(MAX_DEGREE) : degree_i;

  // Candidate wrap past the top of the address space always changes the page bits.
  assign cand_line  = gen_line_reg + LINE_W'(k_reg);
  assign cand_cross = (cand_line[LINE_W-1:PG_LINE_W] != gen_line_reg[LINE_W-1:PG_LINE_W]);

  // One lookup port: the trigger line while idle, the candidate while generating.
  assign lookup_line = (state_reg == HWPF_GEN) ? cand_line : trig_line;

  for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist_cmp
    assign hit_vec[gi] = hist_valid_reg[gi] && (hist_line_reg[gi] == lookup_line);
  end
  assign hist_hit = |hit_vec;

  always_comb begin
    state_next    = state_reg;
    gen_line_next = gen_line_reg;
    deg_next      = deg_reg;
    k_next        = k_reg;
    q_push        = 1'b0;
    hist_wr       = 1'b0;
    drop_ev       = 1'b0;
    case (state_reg)
      HWPF_IDLE: begin
        if (trigger) begin
          if (!hist_hit) begin
            hist_wr = 1'b1;
          end else if (eff_deg != '0) begin
            state_next    = HWPF_GEN;
            gen_line_next = trig_line;
            deg_next      = eff_deg;
            k_next        = DEG_W'(1);
          end
        end
      end
      HWPF_GEN: begin
        if (trigger) drop_ev = 1'b1;
        if (!lock_i) begin
          if (cand_cross) begin
            drop_ev    = 1'b1;
            state_next = HWPF_IDLE;
          end else begin
            if (!hist_hit) begin
              if (!q_full) begin
                q_push  = 1'b1;
                hist_wr = 1'b1;
              end else begin
                drop_ev = 1'b1;
              end
            end
            if (k_reg == deg_reg) state_next = HWPF_IDLE;
            else                  k_next     = k_reg + DEG_W'(1);
          end
        end
      end
      default: state_next = HWPF_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg          <= HWPF_IDLE;
      gen_line_reg       <= '0;
      deg_reg            <= '0;
      k_reg              <= '0;
      last_tid_reg       <= '0;
      last_tid_valid_reg <= 1'b0;
      hist_valid_reg     <= '0;
      hist_ptr_reg       <= '0;
      drop_reg           <= 1'b0;
    end else if (flush_i) begin
      state_reg          <= HWPF_IDLE;
      k_reg              <= '0;
      last_tid_valid_reg <= 1'b0;
      hist_valid_reg     <= '0;
      hist_ptr_reg       <= '0;
      drop_reg           <= 1'b0;
    end else begin
      state_reg    <= state_next;
      gen_line_reg <= gen_line_next;
      deg_reg      <= deg_next;
      k_reg        <= k_next;
      drop_reg     <= drop_ev;
      if (trigger) begin
        last_tid_reg       <= cpu_req_tid_i;
        last_tid_valid_reg <= 1'b1;
      end
      if (hist_wr) begin
        hist_valid_reg[hist_ptr_reg] <= 1'b1;
        hist_ptr_reg <= (hist_ptr_reg == HPTR_W'(HIST_DEPTH - 1)) ? '0
                                                                  : hist_ptr_reg + HPTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (hist_wr && !flush_i) hist_line_reg[hist_ptr_reg] <= lookup_line;
  end

  hwpf_req_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (LINE_W)
  ) u_req_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (q_push),
    .push_data_i (cand_line),
    .pop_i       (q_pop),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_o      (q_head)
  );

  assign arbiter_req_valid_o = ~lock_i & ~q_empty;
  assign q_pop               = arbiter_req_valid_o & arbiter_req_ready_i;
  assign arbiter_req_addr_o  = q_empty ? '0 : {q_head, {LOFF_W{1'b0}}};
  assign drop_o              = drop_reg;

endmodule

// File: tb/tb_hwpf_stream.sv
// Directed bench for hwpf_stream with a two-entry queue; a negedge monitor logs accepted
// requests and drop pulses, and each scenario task checks its own expectations.
module tb_hwpf_stream;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        lock_i = 1'b0;
  logic [2:0]  degree_i = 3'd0;
  logic        cpu_req_valid_i = 1'b0;
  logic [39:0] cpu_req_addr_i = '0;
  logic [6:0]  cpu_req_tid_i = '0;
  logic        arbiter_req_valid_o;
  logic        arbiter_req_ready_i = 1'b0;
  logic [39:0] arbiter_req_addr_o;
  logic        drop_o;

  int checks = 0;
  int failures = 0;
  int drop_cnt = 0;
  logic [39:0] obs [$];

  always #5 clk_i = ~clk_i;

  hwpf_stream #(
    .ADDR_WIDTH  (40),
    .LINE_BYTES  (64),
    .PAGE_BYTES  (4096),
    .HIST_DEPTH  (8),
    .QUEUE_DEPTH (2),
    .MAX_DEGREE  (4),
    .TID_WIDTH   (7)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .lock_i              (lock_i),
    .degree_i            (degree_i),
    .cpu_req_valid_i     (cpu_req_valid_i),
    .cpu_req_addr_i      (cpu_req_addr_i),
    .cpu_req_tid_i       (cpu_req_tid_i),
    .arbiter_req_valid_o (arbiter_req_valid_o),
    .arbiter_req_ready_i (arbiter_req_ready_i),
    .arbiter_req_addr_o  (arbiter_req_addr_o),
    .drop_o              (drop_o)
  );

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (arbiter_req_valid_o && arbiter_req_ready_i) begin
        obs.push_back(arbiter_req_addr_o);
        $display("txn t=%0t prefetch addr=0x%h", $time, arbiter_req_addr_o);
      end
      if (drop_o) drop_cnt <= drop_cnt + 1;
    end
  end

  // All tasks start and end 1ns after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic touch(input logic [39:0] a, input logic [6:0] t);
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = a;
    cpu_req_tid_i   = t;
    @(posedge clk_i);
    #1;
    cpu_req_valid_i = 1'b0;
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (arbiter_req_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", arbiter_req_valid_o); end
    checks++;
    if (arbiter_req_addr_o !== 40'h0) begin failures++; $display("FAIL reset_addr got=0x%h exp=0x0", arbiter_req_addr_o); end
    checks++;
    if (drop_o !== 1'b0) begin failures++; $display("FAIL reset_drop got=%b exp=0", drop_o); end
    rst_ni = 1'b1;
    idle(2);
    checks++;
    if (arbiter_req_valid_o !== 1'b0) begin failures++; $display("FAIL post_reset_valid got=%b exp=0", arbiter_req_valid_o); end
  endtask

  task automatic test_basic_stream();
    int base;
    int dbase;
    do_flush();
    base = obs.size();
    dbase = drop_cnt;
    arbiter_req_ready_i = 1'b1;
    degree_i = 3'd2;
    touch(40'h1000, 7'd1);
    touch(40'h1008, 7'd2);
    @(negedge clk_i);
    checks++;
    if (arbiter_req_valid_o !== 1'b0) begin failures++; $display("FAIL basic_latency_early got=%b exp=0", arbiter_req_valid_o); end
    @(negedge clk_i);
    checks++;
    if (arbiter_req_valid_o !== 1'b1 || arbiter_req_addr_o !== 40'h1040) begin
      failures++; $display("FAIL basic_first_req got v=%b a=0x%h exp v=1 a=0x1040", arbiter_req_valid_o, arbiter_req_addr_o);
    end
    idle(6);
    checks++;
    if (obs.size() - base !== 2) begin failures++; $display("FAIL basic_count got=%0d exp=2", obs.size() - base); end
    checks++;
    if (obs[base] !== 40'h1040) begin failures++; $display("FAIL basic_addr0 got=0x%h exp=0x1040", obs[base]); end
    checks++;
    if (obs[base+1] !== 40'h1080) begin failures++; $display("FAIL basic_addr1 got=0x%h exp=0x1080", obs[base+1]); end
    checks++;
    if (drop_cnt - dbase !== 0) begin failures++; $display("FAIL basic_drops got=%0d exp=0", drop_cnt - dbase); end
  endtask

  task automatic test_page_cross();
    int base;
    int dbase;
    do_flush();
    base = obs.size();
    dbase = drop_cnt;
    arbiter_req_ready_i = 1'b1;
    degree_i = 3'd4;
    touch(40'h1FC0, 7'd3);
    touch(40'h1FC0, 7'd4);
    idle(6);
    checks++;
    if (obs.size() - base !== 0) begin failures++; $display("FAIL page_count got=%0d exp=0", obs.size() - base); end
    checks++;
    if (drop_cnt - dbase !== 1) begin failures++; $display("FAIL page_drops got=%0d exp=1", drop_cnt - dbase); end
  endtask

  task automatic test_queue_full();
    int base;
    int dbase;
    do_flush();
    base = obs.size();
    dbase = drop_cnt;
    arbiter_req_ready_i = 1'b0;
    degree_i = 3'd4;
    touch(40'h2000, 7'd1);
    touch(40'h2000, 7'd2);
    idle(8);
    checks++;
    if (drop_cnt - dbase !== 2) begin failures++; $display("FAIL full_drops got=%0d exp=2", drop_cnt - dbase); end
    checks++;
    if (arbiter_req_valid_o !== 1'b1 || arbiter_req_addr_o !== 40'h2040) begin
      failures++; $display("FAIL full_head got v=%b a=0x%h exp v=1 a=0x2040", arbiter_req_valid_o, arbiter_req_addr_o);
    end
    arbiter_req_ready_i = 1'b1;
    idle(4);
    checks++;
    if (obs.size() - base !== 2) begin failures++; $display("FAIL full_count got=%0d exp=2", obs.size() - base); end
    checks++;
    if (obs[base] !== 40'h2040) begin failures++; $display("FAIL full_addr0 got=0x%h exp=0x2040", obs[base]); end
    checks++;
    if (obs[base+1] !== 40'h2080) begin failures++; $display("FAIL full_addr1 got=0x%h exp=0x2080", obs[base+1]); end
  endtask

  task automatic test_same_tid_and_history();
    int base;
    do_flush();
    base = obs.size();
    arbiter_req_ready_i = 1'b1;
    degree_i = 3'd2;
    cpu_req_valid_i = 1'b1;
    cpu_req_addr_i  = 40'h1000;
    cpu_req_tid_i   = 7'd5;
    idle(3);
    cpu_req_valid_i = 1'b0;
    idle(5);
    checks++;
    if (obs.size() - base !== 0) begin failures++; $display("FAIL same_tid_count got=%0d exp=0", obs.size() - base); end
    touch(40'h1040, 7'd6);
    touch(40'h1000, 7'd7);
    idle(6);
    checks++;
    if (obs.size() - base !== 1) begin failures++; $display("FAIL hist_skip_count got=%0d exp=1", obs.size() - base); end
    checks++;
    if (obs[base] !== 40'h1080) begin failures++; $display("FAIL hist_skip_addr got=0x%h exp=0x1080", obs[base]); end
  endtask

  task automatic test_lock();
    int base;
    do_flush();
    base = obs.size();
    arbiter_req_ready_i = 1'b0;
    degree_i = 3'd1;
    touch(40'h3000, 7'd1);
    touch(40'h3000, 7'd2);
    idle(3);
    checks++;
    if (arbiter_req_valid_o !== 1'b1 || arbiter_req_addr_o !== 40'h3040) begin
      failures++; $display("FAIL lock_pre got v=%b a=0x%h exp v=1 a=0x3040", arbiter_req_valid_o, arbiter_req_addr_o);
    end
    lock_i = 1'b1;
    arbiter_req_ready_i = 1'b1;
    touch(40'h5000, 7'd3);
    idle(2);
    checks++;
    if (arbiter_req_valid_o !== 1'b0) begin failures++; $display("FAIL lock_valid got=%b exp=0", arbiter_req_valid_o); end
    checks++;
    if (obs.size() - base !== 0) begin failures++; $display("FAIL lock_pop got=%0d exp=0", obs.size() - base); end
    lock_i = 1'b0;
    idle(3);
    checks++;
    if (obs.size() - base !== 1) begin failures++; $display("FAIL unlock_count got=%0d exp=1", obs.size() - base); end
    checks++;
    if (obs[base] !== 40'h3040) begin failures++; $display("FAIL unlock_addr got=0x%h exp=0x3040", obs[base]); end
    touch(40'h5000, 7'd4);
    idle(4);
    checks++;
    if (obs.size() - base !== 1) begin failures++; $display("FAIL lock_trigger_ignored got=%0d exp=1", obs.size() - base); end
  endtask

  task automatic test_flush_mid_gen();
    int base;
    do_flush();
    base = obs.size();
    arbiter_req_ready_i = 1'b0;
    degree_i = 3'd4;
    touch(40'h4000, 7'd1);
    touch(40'h4000, 7'd2);
    idle(1);
    checks++;
    if (arbiter_req_valid_o !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%b exp=1", arbiter_req_valid_o); end
    do_flush();
    checks++;
    if (arbiter_req_valid_o !== 1'b0) begin failures++; $display("FAIL flush_queue_empty got=%b exp=0", arbiter_req_valid_o); end
    arbiter_req_ready_i = 1'b1;
    idle(3);
    checks++;
    if (obs.size() - base !== 0) begin failures++; $display("FAIL flush_fsm_idle got=%0d exp=0", obs.size() - base); end
    touch(40'h4000, 7'd3);
    idle(6);
    checks++;
    if (obs.size() - base !== 0) begin failures++; $display("FAIL flush_hist_miss got=%0d exp=0", obs.size() - base); end
    touch(40'h4000, 7'd4);
    idle(8);
    checks++;
    if (obs.size() - base !== 4) begin failures++; $display("FAIL flush_reconfirm_count got=%0d exp=4", obs.size() - base); end
    checks++;
    if (obs[base] !== 40'h4040) begin failures++; $display("FAIL flush_reconfirm_addr0 got=0x%h exp=0x4040", obs[base]); end
    checks++;
    if (obs[base+3] !== 40'h4100) begin failures++; $display("FAIL flush_reconfirm_addr3 got=0x%h exp=0x4100", obs[base+3]); end
  endtask

  task automatic test_async_reset();
    int base;
    do_flush();
    arbiter_req_ready_i = 1'b0;
    degree_i = 3'd4;
    touch(40'h6000, 7'd1);
    touch(40'h6000, 7'd2);
    idle(1);
    checks++;
    if (arbiter_req_valid_o !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%b exp=1", arbiter_req_valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (arbiter_req_valid_o !== 1'b0 || arbiter_req_addr_o !== 40'h0) begin
      failures++; $display("FAIL areset_immediate got v=%b a=0x%h exp v=0 a=0x0", arbiter_req_valid_o, arbiter_req_addr_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    base = obs.size();
    arbiter_req_ready_i = 1'b1;
    idle(6);
    checks++;
    if (obs.size() - base !== 0) begin failures++; $display("FAIL areset_gen_aborted got=%0d exp=0", obs.size() - base); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_page_cross();
    test_queue_full();
    test_same_tid_and_history();
    test_lock();
    test_flush_mid_gen();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hwpf_stream.md
# hwpf_stream

Parametrised next-N-line prefetcher for the Sargantana data cache, the successor to the single-line next-line prefetcher. It observes CPU load requests, confirms a stream when a line is touched twice, then issues up to `degree` sequential line prefetches through an internal issue queue to the HPDcache arbiter. Generated prefetches stay inside a page, are de-duplicated against a history table, and are throttled by queue occupancy.

## Interface
Parameters:
- `ADDR_WIDTH`, 40: byte address width.
- `LINE_BYTES`, 64: cache line size in bytes; power of two.
- `PAGE_BYTES`, 4096: prefetches never cross this boundary; power of two, ≥ `LINE_BYTES`.
- `HIST_DEPTH`, 8: history table entries.
- `QUEUE_DEPTH`, 8: issue queue entries; power of two.
- `MAX_DEGREE`, 4: maximum prefetches per trigger.
- `TID_WIDTH`, 7: CPU request tag width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: synchronous clear of all state.
- `lock_i`, in, 1: freeze triggers and issue.
- `degree_i`, in, `$clog2(MAX_DEGREE+1)`: prefetch degree; 0 disables the prefetcher.
- `cpu_req_valid_i`, in, 1: CPU request present.
- `cpu_req_addr_i`, in, `ADDR_WIDTH`: CPU byte address.
- `cpu_req_tid_i`, in, `TID_WIDTH`: CPU request tag.
- `arbiter_req_valid_o`, out, 1: prefetch request valid.
- `arbiter_req_ready_i`, in, 1: arbiter accepts.
- `arbiter_req_addr_o`, out, `ADDR_WIDTH`: line-aligned prefetch address.
- `drop_o`, out, 1: one-cycle pulse when a trigger or candidate is discarded.

## Operation
- Trigger: `cpu_req_valid_i & ~lock_i` and (`last_tid_valid` is 0 or `cpu_req_tid_i` differs from `last_tid`). Every trigger updates `last_tid`.
- Line address L = addr >> log2(LINE_BYTES). Lookup compares L against all valid history entries.
- Miss: insert L at the round-robin pointer; the pointer wraps modulo `HIST_DEPTH`. No prefetch.
- Hit with effective degree D = min(`degree_i`, `MAX_DEGREE`) > 0: FSM IDLE→GEN, latching L, D, and k=1.
- GEN, one candidate per cycle, C = L+k:
  - If C lies in a different page than L, drop it and go to IDLE.
  - If C hits in history, skip it.
  - Otherwise, if the queue is not full, push C and insert C into history.
  - If the queue is full, drop C and pulse `drop_o`.
  - Then k++. After k=D, go to IDLE.
- A trigger arriving while in GEN updates `last_tid` but is otherwise discarded, and `drop_o` pulses.
- The head of the queue drives the output; the entry pops on `valid & ready`.
- `lock_i`: triggers are ignored, the FSM holds, `arbiter_req_valid_o` is 0, and no pops occur. `lock_i` overrides the valid-stability rule.
- `flush_i` (lower priority than reset, higher than everything else): clears history, queue, `last_tid_valid`, and k, and moves the FSM to IDLE. Takes effect at the next edge.

## Timing
- Reset values: `arbiter_req_valid_o`=0, `arbiter_req_addr_o`=0, `drop_o`=0. History is all invalid, the queue is empty, the FSM is IDLE.
- Cycle sequence for a confirming trigger:
  - The trigger is sampled at edge N and the FSM enters GEN.
  - The first candidate is pushed at edge N+1.
  - `arbiter_req_valid_o` is high during cycle N+1→N+2.
  - One further candidate follows per cycle.
- Once asserted, valid and addr hold until accepted (unless `lock_i` or `flush_i` intervenes).
- Full check uses the registered count. A push when count==`QUEUE_DEPTH` is rejected even if a pop occurs in the same cycle. A simultaneous push and pop on a non-full queue keeps the count.
- Address arithmetic is in line units, `ADDR_WIDTH`-log2(`LINE_BYTES`) bits, with no wrap past the top because the page check precedes it.
- Reset asserted mid-GEN aborts immediately, asynchronously.

## Structure
- Shared package `hwpf_pkg`: `line_addr_t`, `LINE_OFF_W`, `PAGE_OFF_W`, and the FSM enum `hwpf_gen_state_e`.
- Sub-module `hwpf_req_queue`: parametrised FIFO with registered count, `full`/`empty`, and head output. History table and FSM stay in the top level.

## Test plan
- Trigger 0x1000 tid 1, then 0x1008 tid 2 with `degree_i`=2 → two requests, 0x1040 then 0x1080, with ready held high.
- Trigger 0x1FC0 twice with `degree_i`=4 → no request (page crossing), `drop_o` pulses once.
- `QUEUE_DEPTH`=2, ready=0, confirm at 0x2000 with degree 4 → queue holds 0x2040 and 0x2080; `drop_o` pulses for 0x20C0 and 0x2100.
- Repeat the same tid on consecutive cycles → one trigger only; a second confirmation of 0x1000 after 0x1040 is already in history issues only 0x1080.
- `lock_i` held during a pending valid → valid is 0 and the entry is retained; after release, the same address is reissued.
- `flush_i` mid-GEN → queue empty and FSM IDLE next cycle; the next touch of the old line is a history miss and produces no prefetch.
